// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI initiator that drives the SPI slave + RAM wrapper.
// Contents: command opcode enum, controller state enum, frame bit-count constants.
// No logic. Imported by the interface, the shifter and the top.
package spi_master_ctrl_pkg;

  // Two-bit command opcode. The MSB is the direction bit the slave checks first.
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    GAP   = 3'd5
  } master_state_e;

  localparam int CMD_BITS = 10;  // opcode + payload sent per frame
  localparam int RD_BITS  = 8;   // reply bits captured on a read-data frame

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command / response bundle between a requester and spi_master_ctrl.
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_data (request), rsp_valid/rsp_data/rsp_err (reply).
// Modports: master = requester side, slave = controller side.
interface spi_master_ctrl_if;
  import spi_master_ctrl_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  spi_op_e            cmd_op;
  logic [RD_BITS-1:0] cmd_data;
  logic               rsp_valid;
  logic [RD_BITS-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/spi_master_ctrl_shifter.sv
// Loadable 10-bit PISO plus 8-bit SIPO sharing one down-counter, for spi_master_ctrl.
// Ports: clk, rst_n, load/load_dat (new frame), shift_en (one TX bit), capture_en (one RX bit),
//        miso in; mosi_bit (TX bit for this cycle), bit_done (this is the last bit of the phase), rx_byte.
module spi_master_shifter
  import spi_master_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CMD_BITS-1:0] load_dat,
  input  logic                shift_en,
  input  logic                capture_en,
  input  logic                miso,
  output logic                mosi_bit,
  output logic                bit_done,
  output logic [RD_BITS-1:0]  rx_byte
);

  logic [CMD_BITS-1:0] tx_sr;
  logic [RD_BITS-2:0]  rx_sr;   // only 7 bits stored; the 8th comes straight from miso
  logic [3:0]          cnt;

  // TX is indexed rather than shifted so the frame image stays intact for the whole frame.
  assign mosi_bit = tx_sr[cnt];
  assign bit_done = (cnt == 4'd0);
  // Byte as it will be once the current MISO bit is captured; the FSM latches this on the last sample.
  assign rx_byte  = {rx_sr, miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
      rx_sr <= '0;
      cnt   <= '0;
    end else if (load) begin
      tx_sr <= load_dat;
      rx_sr <= '0;
      cnt   <= 4'(CMD_BITS - 1);
    end else if (shift_en) begin
      // After the last TX bit the counter is re-armed for the receive phase.
      cnt <= bit_done ? 4'(RD_BITS - 1) : cnt - 4'd1;
    end else if (capture_en) begin
      rx_sr <= rx_byte[RD_BITS-2:0];
      if (!bit_done) cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises {op,data} commands into one SS_n frame, captures the 8-bit reply of read-data.
// Ports: clk, rst_n, bus (spi_master_ctrl_if.slave command/response), SS_n, MOSI, MISO.
// Optional build macro SPI_MASTER_RD_ORDER_CHK_EN: reject read-data not preceded by a read-address frame.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int RD_LAT  = 2,  // 1..15, cycles from last command bit to first MISO sample
  parameter int GAP_CYC = 1   // 1..15, minimum SS_n-high cycles between frames
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  master_state_e      state, state_n;
  logic               ss_n_q, ss_n_n;
  logic               mosi_q, mosi_n;
  logic               rsp_valid_q, rsp_valid_n;
  logic [RD_BITS-1:0] rsp_data_q, rsp_data_n;
  spi_op_e            op_q, op_n;
  logic [3:0]         wait_cnt, wait_n;
  logic [3:0]         gap_cnt, gap_n;

  logic               load, shift_en, capture_en;
  logic               mosi_bit, bit_done;
  logic [RD_BITS-1:0] rx_byte;
  logic               accept;

`ifdef SPI_MASTER_RD_ORDER_CHK_EN
  logic rej_q, rej_n;          // accepted command is a read-data that must not go on the wire
  logic rsp_err_q, rsp_err_n;
  logic pend_q, pend_n;        // a read-address frame has completed and is waiting for its read-data
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_dat   ({bus.cmd_op, bus.cmd_data}),
    .shift_en   (shift_en),
    .capture_en (capture_en),
    .miso       (MISO),
    .mosi_bit   (mosi_bit),
    .bit_done   (bit_done),
    .rx_byte    (rx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      op_q        <= WR_ADDR;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_n;
      ss_n_q      <= ss_n_n;
      mosi_q      <= mosi_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      op_q        <= op_n;
      wait_cnt    <= wait_n;
      gap_cnt     <= gap_n;
    end
  end

`ifdef SPI_MASTER_RD_ORDER_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      rej_q     <= rej_n;
      rsp_err_q <= rsp_err_n;
      pend_q    <= pend_n;
    end
  end
`endif

  always_comb begin
    state_n     = state;
    ss_n_n      = ss_n_q;
    mosi_n      = mosi_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    op_n        = op_q;
    wait_n      = wait_cnt;
    gap_n       = gap_cnt;
    load        = 1'b0;
    shift_en    = 1'b0;
    capture_en  = 1'b0;
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
    rej_n       = rej_q;
    rsp_err_n   = 1'b0;
    pend_n      = pend_q;
`endif

    unique case (state)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          op_n    = bus.cmd_op;
          mosi_n  = 1'b0;
          state_n = START;
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
          rej_n   = (bus.cmd_op == RD_DATA) && !pend_q;
          ss_n_n  = rej_n;  // a rejected command never drops SS_n
`else
          ss_n_n  = 1'b0;
`endif
        end
      end

      START: begin
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
        if (rej_q) begin
          rsp_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
`else
        begin
`endif
          // Direction bit leads the frame so the slave can classify it before the opcode arrives.
          mosi_n  = op_q[1];
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        shift_en = 1'b1;
        mosi_n   = mosi_bit;
        if (bit_done) begin
          // First edge of WAIT/GAP is the frame-end edge that returns MOSI to 0.
          if (op_q == RD_DATA) begin
            state_n = WAIT;
            wait_n  = 4'(RD_LAT);
          end else begin
            state_n = GAP;
            gap_n   = 4'(GAP_CYC);
          end
        end
      end

      WAIT: begin
        mosi_n = 1'b0;
        if (wait_cnt == 4'd0) state_n = RECV;
        else                  wait_n  = wait_cnt - 4'd1;
      end

      RECV: begin
        capture_en = 1'b1;
        if (bit_done) begin
          rsp_data_n  = rx_byte;
          rsp_valid_n = 1'b1;
          ss_n_n      = 1'b1;
          state_n     = GAP;
          // SS_n rises on this edge already, so one fewer GAP edge keeps the same high time as writes.
          gap_n       = 4'(GAP_CYC - 1);
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
          pend_n      = 1'b0;
`endif
        end
      end

      GAP: begin
        ss_n_n = 1'b1;
        mosi_n = 1'b0;
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
        if (op_q == RD_ADDR) pend_n = 1'b1;
`endif
        if (gap_cnt == 4'd0) state_n = IDLE;
        else                 gap_n   = gap_cnt - 4'd1;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM on SS_n/MOSI/MISO.
// Expected frame lengths, bit sequences and read data are hand-derived constants.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  localparam int RD_LAT  = 3;
  localparam int GAP_CYC = 2;

  logic clk;
  logic rst_n;
  logic SS_n, MOSI;
  bit   MISO;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural slave + RAM: collects the 10 frame bits, replies MSB first for read-data.
  bit [7:0]    ram [256];
  bit [7:0]    wa, ra, miso_sr;
  bit [9:0]    fr;
  logic [10:0] mosi_seq = '0;
  int          sj = 0;

  always @(negedge clk) begin
    if (SS_n) begin
      sj   = 0;
      MISO = 1'b0;
    end else begin
      if (sj >= 1 && sj <= 11) mosi_seq = {mosi_seq[9:0], MOSI};
      if (sj >= 2 && sj <= 11) fr = {fr[8:0], MOSI};
      if (sj == 11) begin
        case (fr[9:8])
          2'b00:   wa = fr[7:0];
          2'b01:   ram[wa] = fr[7:0];
          2'b10:   ra = fr[7:0];
          default: miso_sr = ram[ra];
        endcase
      end
      if (sj >= 12 + RD_LAT && sj <= 19 + RD_LAT) begin
        MISO    = miso_sr[7];
        miso_sr = miso_sr << 1;
      end else begin
        MISO = 1'b0;
      end
      sj++;
    end
  end

  // Pin monitor: frame lengths, SS_n-high gaps, response pulse counts.
  int lo_run = 0, hi_run = 0, last_len = 0, last_gap = 0, frames = 0;
  int nvalid = 0, nerr = 0, nboth = 0;

  always @(negedge clk) begin
    if (!SS_n) begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
      lo_run++;
    end else begin
      if (lo_run != 0) begin
        last_len = lo_run;
        frames++;
      end
      lo_run = 0;
      hi_run++;
    end
    if (bus.rsp_valid) nvalid++;
    if (bus.rsp_err) nerr++;
    if (bus.rsp_valid && bus.rsp_err) nboth++;
  end

  // Per-transaction observations, indexed by negedges after the accept edge (0 = just after E0).
  int rsp_at, err_at, busy_cyc;
  logic [7:0] rsp_got;

  task automatic xfer(input spi_op_e op, input logic [7:0] d);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("accept_tmo", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request after acceptance; the frame in flight must not change.
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = ~d;
    bus.cmd_op    = RD_DATA;
    rsp_at  = -1;
    err_at  = -1;
    rsp_got = 8'h00;
    busy_cyc = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      busy_cyc = cyc;
      if (bus.rsp_valid) begin
        rsp_at  = cyc;
        rsp_got = bus.rsp_data;
      end
      if (bus.rsp_err) err_at = cyc;
      if (bus.cmd_ready) break;
      @(negedge clk);
    end
    if (!bus.cmd_ready) chk("done_tmo", bus.cmd_ready, 1);
    #1;
  endtask

  int v_valid, v_err, v_fr;
  spi_op_e b2b_op [4];
  logic [7:0] b2b_dat [4];

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = WR_ADDR;
    bus.cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Read-data straight after reset: rejected with the order check, otherwise a full read frame.
    v_valid = nvalid; v_err = nerr; v_fr = frames;
    xfer(RD_DATA, 8'h00);
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
    chk("rej_err_cnt", nerr - v_err, 1);
    chk("rej_err_at", err_at, 1);
    chk("rej_no_frame", frames - v_fr, 0);
    chk("rej_no_rsp", nvalid - v_valid, 0);
`else
    chk("rd0_len", last_len, 20 + RD_LAT);
    chk("rd0_rsp_at", rsp_at, 20 + RD_LAT);
    chk("rd0_data", rsp_got, 8'h00);
    chk("rd0_no_err", nerr - v_err, 0);
`endif

    // Write-address A5: 12-cycle frame, exact MOSI bit order, busy until the gap ends.
    v_valid = nvalid;
    xfer(WR_ADDR, 8'hA5);
    chk("a5_len", last_len, 12);
    chk("a5_mosi", mosi_seq, 11'b000_1010_0101);
    chk("a5_busy", busy_cyc, 12 + GAP_CYC);
    chk("a5_no_rsp", nvalid - v_valid, 0);

    // RAM round trip through the slave.
    xfer(WR_ADDR, 8'h10);
    xfer(WR_DATA, 8'h3C);
    xfer(RD_ADDR, 8'h10);
    v_valid = nvalid;
    xfer(RD_DATA, 8'h00);
    chk("rd_data", rsp_got, 8'h3C);
    chk("rd_rsp_at", rsp_at, 20 + RD_LAT);
    chk("rd_len", last_len, 20 + RD_LAT);
    chk("rd_pulses", nvalid - v_valid, 1);
    chk("rd_busy", busy_cyc, 20 + RD_LAT + GAP_CYC);
    xfer(WR_ADDR, 8'h55);
    chk("rsp_hold", bus.rsp_data, 8'h3C);

    // Four writes with cmd_valid held high throughout.
    b2b_op[0] = WR_ADDR; b2b_dat[0] = 8'h20;
    b2b_op[1] = WR_DATA; b2b_dat[1] = 8'h11;
    b2b_op[2] = WR_ADDR; b2b_dat[2] = 8'h21;
    b2b_op[3] = WR_DATA; b2b_dat[3] = 8'h22;
    v_fr = frames;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = b2b_op[0];
    bus.cmd_data  = b2b_dat[0];
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.cmd_ready) chk("b2b_tmo", bus.cmd_ready, 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (i > 0) chk($sformatf("b2b_gap%0d", i), last_gap, GAP_CYC + 1);
      if (i < 3) begin
        bus.cmd_op   = b2b_op[i+1];
        bus.cmd_data = b2b_dat[i+1];
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    for (int n = 0; n < 100 && !bus.cmd_ready; n++) @(negedge clk);
    #1;
    chk("b2b_frames", frames - v_fr, 4);
    xfer(RD_ADDR, 8'h21);
    xfer(RD_DATA, 8'h00);
    chk("b2b_rd21", rsp_got, 8'h22);
    xfer(RD_ADDR, 8'h20);
    xfer(RD_DATA, 8'h00);
    chk("b2b_rd20", rsp_got, 8'h11);

    // 1000_0001 reply: MSB-first capture at RD_LAT=3.
    xfer(WR_ADDR, 8'h40);
    xfer(WR_DATA, 8'h81);
    xfer(RD_ADDR, 8'h40);
    xfer(RD_DATA, 8'h00);
    chk("rd81_data", rsp_got, 8'h81);
    chk("rd81_rsp_at", rsp_at, 20 + RD_LAT);

    // Async reset in the middle of a write-data frame.
    xfer(WR_ADDR, 8'h30);
    v_valid = nvalid;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = WR_DATA;
    bus.cmd_data  = 8'h77;
    for (int n = 0; n < 100 && !bus.cmd_ready; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", SS_n, 1);
    chk("mid_rst_mosi", MOSI, 0);
    @(negedge clk);
    #1;
    chk("mid_rst_len", last_len, 6);
    chk("mid_rst_no_rsp", nvalid - v_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(WR_DATA, 8'h5A);
    chk("post_rst_len", last_len, 12);
    xfer(RD_ADDR, 8'h30);
    xfer(RD_DATA, 8'h00);
    chk("post_rst_rd", rsp_got, 8'h5A);

    chk("never_both", nboth, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
